// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sequencer slice.
package ppu_pkg;

    localparam int PPU_PSUM_W  = 32;
    localparam int PPU_DIM_W   = 8;
    localparam int PPU_ADDR_W  = 16;
    localparam int PPU_SCALE_W = 6;
    localparam int POOL_WIN    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        FLUSH,
        DONE
    } ppu_ctrl_state_e;

    typedef struct packed {
        logic [PPU_DIM_W-1:0]   h;
        logic [PPU_DIM_W-1:0]   w;
        logic                   pool;
        logic                   relu;
        logic [PPU_SCALE_W-1:0] scale;
        logic [PPU_ADDR_W-1:0]  base;
    } ppu_cfg_t;

    // Number of results a tile produces; odd trailing rows/cols are dropped when pooling.
    function automatic logic [2*PPU_DIM_W-1:0] tile_total(input ppu_cfg_t cfg);
        logic [2*PPU_DIM_W-1:0] hh;
        logic [2*PPU_DIM_W-1:0] ww;
        hh = (2*PPU_DIM_W)'(cfg.h);
        ww = (2*PPU_DIM_W)'(cfg.w);
        if (cfg.pool) begin
            hh = hh >> 1;
            ww = ww >> 1;
        end
        return hh * ww;
    endfunction

endpackage

// File: rtl/ppu_out_reg.sv
// One-entry valid/ready output register holding a result byte and its address.
module ppu_out_reg #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              free_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;

    // Free when empty or draining this cycle, so a load may overwrite a departing entry.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign addr_o  = addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            addr_q  <= addr_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ppu_ctrl.sv
// Tile sequencer for one PPU: forwards psums, drives maxpool/ReLU controls and
// streams each int8 result with its address. cfg fields use the package widths.
module ppu_ctrl
    import ppu_pkg::*;
#(
    parameter int PSUM_W = PPU_PSUM_W,
    parameter int DIM_W  = PPU_DIM_W,
    parameter int ADDR_W = PPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic              cfg_pool,
    input  logic              cfg_relu,
    input  logic [5:0]        cfg_scale,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum_data,
    output logic [PSUM_W-1:0] ppu_data_in,
    output logic [5:0]        ppu_scale,
    output logic              ppu_maxpool_init,
    output logic              ppu_maxpool_en,
    output logic              ppu_relu_sel,
    output logic              ppu_relu_en,
    input  logic [7:0]        ppu_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = 2*DIM_W;
    localparam int WIN_W = $clog2(POOL_WIN);

    ppu_ctrl_state_e   state_q, state_d;
    ppu_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;

    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  out_idx_inc;
    logic [ADDR_W-1:0] load_addr;
    logic              out_free;
    logic              out_load;
    logic              fire;

    assign total       = tile_total(cfg_q);
    assign out_idx_inc = out_idx_q + 1'b1;
    assign load_addr   = cfg_q.base + ADDR_W'(out_idx_q);

    assign ppu_data_in = psum_data;
    assign ppu_scale   = cfg_q.scale;
    assign ppu_relu_en = cfg_q.relu;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_comb begin
        state_d          = state_q;
        cfg_d            = cfg_q;
        out_idx_d        = out_idx_q;
        win_cnt_d        = win_cnt_q;
        psum_ready       = 1'b0;
        fire             = 1'b0;
        ppu_maxpool_init = 1'b0;
        ppu_maxpool_en   = 1'b0;
        ppu_relu_sel     = 1'b0;
        out_load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d.h     = cfg_h;
                    cfg_d.w     = cfg_w;
                    cfg_d.pool  = cfg_pool;
                    cfg_d.relu  = cfg_relu;
                    cfg_d.scale = cfg_scale;
                    cfg_d.base  = cfg_base;
                    out_idx_d   = '0;
                    win_cnt_d   = '0;
                    state_d     = (tile_total(cfg_d) == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                psum_ready = out_free;
                fire       = psum_valid && psum_ready;
                if (fire) begin
                    if (cfg_q.pool) begin
                        ppu_maxpool_init = (win_cnt_q == '0);
                        ppu_maxpool_en   = (win_cnt_q != '0);
                        win_cnt_d        = win_cnt_q + 1'b1;
                        if (win_cnt_q == WIN_W'(POOL_WIN-1)) begin
                            state_d = CAPTURE;
                        end
                    end else begin
                        out_load  = 1'b1;
                        out_idx_d = out_idx_inc;
                        if (out_idx_inc == total) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            // The PPU pool register now holds the window max; hold here until the output slot frees.
            CAPTURE: begin
                ppu_relu_sel = 1'b1;
                if (out_free) begin
                    out_load  = 1'b1;
                    out_idx_d = out_idx_inc;
                    state_d   = (out_idx_inc == total) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            out_idx_q <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            out_idx_q <= out_idx_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    ppu_out_reg #(
        .DATA_W (8),
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (out_load),
        .data_i  (ppu_data_out),
        .addr_i  (load_addr),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .addr_o  (out_addr),
        .free_o  (out_free)
    );

endmodule

// File: tb/tb_ppu_ctrl.sv
// Self-checking bench for ppu_ctrl with a behavioural PPU stub and a
// window-level reference model of the expected result stream.
module tb_ppu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_h;
    logic [7:0]  cfg_w;
    logic        cfg_pool;
    logic        cfg_relu;
    logic [5:0]  cfg_scale;
    logic [15:0] cfg_base;
    logic        psum_valid;
    logic        psum_ready;
    logic [31:0] psum_data;
    logic [31:0] ppu_data_in;
    logic [5:0]  ppu_scale;
    logic        ppu_maxpool_init;
    logic        ppu_maxpool_en;
    logic        ppu_relu_sel;
    logic        ppu_relu_en;
    logic [7:0]  ppu_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int          psums[$];
    logic [7:0]  got_data[$];
    logic [15:0] got_addr[$];
    int          fire_cyc[$];
    int fire_n, init_n, en_n, rs_n, bad_n, stall_leak, stab_err, thru_err;
    int done_cyc, first_ov, last_hs;
    int mp;
    bit seen;

    ppu_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_h            (cfg_h),
        .cfg_w            (cfg_w),
        .cfg_pool         (cfg_pool),
        .cfg_relu         (cfg_relu),
        .cfg_scale        (cfg_scale),
        .cfg_base         (cfg_base),
        .psum_valid       (psum_valid),
        .psum_ready       (psum_ready),
        .psum_data        (psum_data),
        .ppu_data_in      (ppu_data_in),
        .ppu_scale        (ppu_scale),
        .ppu_maxpool_init (ppu_maxpool_init),
        .ppu_maxpool_en   (ppu_maxpool_en),
        .ppu_relu_sel     (ppu_relu_sel),
        .ppu_relu_en      (ppu_relu_en),
        .ppu_data_out     (ppu_data_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_addr         (out_addr),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Post-quant: arithmetic shift, saturate to int8, optional ReLU.
    function automatic logic [7:0] ppu_f(input int v, input int scale, input bit relu);
        int s;
        s = v >>> scale;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return s[7:0];
    endfunction

    // PPU stub: maxpool register plus combinational quant/ReLU output.
    always_ff @(posedge clk) begin
        if (ppu_maxpool_init) mp <= int'($signed(ppu_data_in));
        else if (ppu_maxpool_en && int'($signed(ppu_data_in)) > mp) mp <= int'($signed(ppu_data_in));
    end

    assign ppu_data_out = ppu_f(ppu_relu_sel ? mp : int'($signed(ppu_data_in)), int'(ppu_scale), ppu_relu_en);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one tile end to end and compares the result stream with the model.
    // pmode: 0 = psums back-to-back, 1 = random gaps. rmode: 0 = ready high,
    // 1 = random ready, 2 = ready low on cycles 3..7. poke: extra start mid-tile.
    task automatic run_tile(input int h, input int w, input bit pool, input bit relu,
                            input int scale, input logic [15:0] base, input int extra,
                            input int pmode, input int rmode, input bit poke, input bit gen);
        int total, need, idx, cyc, m;
        bit fired, prev_hold;
        logic [7:0]  pd;
        logic [15:0] pa;
        total = pool ? (h / 2) * (w / 2) : h * w;
        need  = pool ? 4 * total : total;
        if (gen) begin
            psums.delete();
            for (int i = 0; i < need + extra; i++) psums.push_back(int'($urandom_range(2000, 0)) - 1000);
        end
        got_data.delete(); got_addr.delete(); fire_cyc.delete();
        fire_n = 0; init_n = 0; en_n = 0; rs_n = 0; bad_n = 0;
        stall_leak = 0; stab_err = 0; thru_err = 0;
        done_cyc = -1; first_ov = -1; last_hs = -1;
        prev_hold = 0; pd = '0; pa = '0; idx = 0; cyc = 0;

        @(posedge clk); #1;
        cfg_h = 8'(h); cfg_w = 8'(w); cfg_pool = pool; cfg_relu = relu;
        cfg_scale = 6'(scale); cfg_base = base; start = 1'b1;
        psum_valid = 1'b0; out_ready = 1'b1;

        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            fired = psum_valid && psum_ready;
            if (fired) begin fire_n++; fire_cyc.push_back(cyc); end
            if (ppu_maxpool_init) init_n++;
            if (ppu_maxpool_en) en_n++;
            if (ppu_relu_sel) begin rs_n++; if (psum_ready) bad_n++; end
            if (out_valid && !out_ready && psum_ready) stall_leak++;
            if (prev_hold && (!out_valid || out_data !== pd || out_addr !== pa)) stab_err++;
            prev_hold = out_valid && !out_ready; pd = out_data; pa = out_addr;
            if (ppu_data_in !== psum_data) thru_err++;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_addr.push_back(out_addr); last_hs = cyc;
            end
            if (done) done_cyc = cyc;
            if (cyc == 1) begin
                check("ppu_scale", 32'(ppu_scale), 32'(scale));
                check("ppu_relu_en", 32'(ppu_relu_en), 32'(relu));
                check("busy_running", 32'(busy), 1);
            end

            @(posedge clk); #1;
            cyc++;
            if (fired) idx++;
            start = 1'b0; cfg_base = base; cfg_pool = pool;
            if (poke && cyc == 2) begin start = 1'b1; cfg_base = ~base; cfg_pool = !pool; end
            if (idx < psums.size()) begin
                if (!(psum_valid && !fired)) psum_valid = (pmode == 0) || ($urandom_range(3, 0) != 0);
                psum_data = 32'(psums[idx]);
            end else begin
                psum_valid = 1'b0;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = !(cyc >= 3 && cyc < 8);
            endcase
        end
        psum_valid = 1'b0; out_ready = 1'b1;

        check("done_seen", 32'(done_cyc >= 0), 1);
        check("psums_accepted", fire_n, need);
        check("out_count", got_data.size(), total);
        for (int k = 0; k < total && k < got_data.size(); k++) begin
            if (pool) begin
                m = psums[4*k];
                for (int j = 1; j < 4; j++) if (psums[4*k+j] > m) m = psums[4*k+j];
            end else begin
                m = psums[k];
            end
            check($sformatf("out_data[%0d]", k), 32'(got_data[k]), 32'(ppu_f(m, scale, relu)));
            check($sformatf("out_addr[%0d]", k), 32'(got_addr[k]), 32'(16'(base + 16'(k))));
        end
        check("init_pulses", init_n, pool ? total : 0);
        check("en_pulses", en_n, pool ? 3 * total : 0);
        check("relu_sel_cycles", 32'(pool ? (rs_n >= total) : (rs_n == 0)), 1);
        check("relu_sel_with_ready", bad_n, 0);
        check("stall_ready_leak", stall_leak, 0);
        check("out_hold_stable", stab_err, 0);
        check("data_passthrough", thru_err, 0);
        if (total == 0) begin
            check("zero_done_latency", done_cyc, 1);
            check("zero_no_output", first_ov, -1);
        end else begin
            check("done_after_last_hs", done_cyc - last_hs, 1);
        end
        if (pmode == 0 && rmode == 0 && total > 0 && !pool)
            check("bypass_latency", first_ov - fire_cyc[0], 1);
        if (pmode == 0 && rmode == 0 && pool && fire_cyc.size() >= 4)
            check("pool_latency", first_ov - fire_cyc[3], 2);
        if (pmode == 0 && rmode == 0 && pool && fire_cyc.size() >= 5)
            check("pool_throughput", fire_cyc[4] - fire_cyc[0], 5);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 0);
        check("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_h = '0; cfg_w = '0; cfg_pool = 1'b0; cfg_relu = 1'b0;
        cfg_scale = '0; cfg_base = '0; psum_valid = 1'b0; psum_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_psum_ready", 32'(psum_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_ppu_scale", 32'(ppu_scale), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed bypass with fixed psums, ReLU on
        psums = {5, -3, 7, 0};
        run_tile(2, 2, 1'b0, 1'b1, 0, 16'h0010, 0, 0, 0, 1'b0, 1'b0);
        // Pool 2x4 back-to-back
        run_tile(2, 4, 1'b1, 1'b0, 2, 16'h0100, 0, 0, 0, 1'b0, 1'b1);
        // Backpressure on a 3x3 bypass tile
        run_tile(3, 3, 1'b0, 1'b0, 1, 16'h0020, 0, 0, 2, 1'b0, 1'b1);
        // Empty tile and odd pooled tile with surplus psums offered
        run_tile(0, 5, 1'b0, 1'b0, 0, 16'h0030, 0, 0, 0, 1'b0, 1'b1);
        run_tile(3, 3, 1'b1, 1'b1, 0, 16'h0050, 4, 0, 0, 1'b0, 1'b1);

        // Reset while the controller sits in CAPTURE
        @(posedge clk); #1;
        cfg_h = 8'd2; cfg_w = 8'd4; cfg_pool = 1'b1; cfg_relu = 1'b1; cfg_scale = 6'd1;
        cfg_base = 16'h0040; start = 1'b1; out_ready = 1'b1; psum_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; psum_valid = 1'b1; psum_data = 32'd77;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ppu_relu_sel) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("capture_reached", 32'(seen), 1);
        rst = 1'b1; psum_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_relu_sel", 32'(ppu_relu_sel), 0);
        check("midrst_relu_en", 32'(ppu_relu_en), 0);
        check("midrst_out_data", 32'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_tile(2, 3, 1'b0, 1'b0, 0, 16'h0040, 0, 0, 0, 1'b0, 1'b1);

        // start while busy is ignored
        run_tile(2, 3, 1'b0, 1'b1, 1, 16'h0300, 0, 0, 0, 1'b1, 1'b1);
        run_tile(4, 4, 1'b1, 1'b0, 3, 16'h0400, 0, 0, 1, 1'b1, 1'b1);
        // Address wrap
        run_tile(1, 2, 1'b0, 1'b0, 0, 16'hFFFF, 0, 0, 0, 1'b0, 1'b1);

        // Randomized tiles
        for (int t = 0; t < 8; t++) begin
            run_tile(int'($urandom_range(5, 0)), int'($urandom_range(5, 0)), 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), int'($urandom_range(4, 0)), 16'($urandom),
                     int'($urandom_range(2, 0)), 1, 1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
